// File: rtl/dvl_cap_pkg.sv
// Shared constants and entry-layout helpers for the stream capture block.
// The entry layout is {data, timestamp, drop flag}, with the drop flag at bit 0.
package dvl_cap_pkg;

    localparam int DROP_CNT_W = 32'sd16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    function automatic int ent_drop_lsb();
        return 32'sd0;
    endfunction

    function automatic int ent_ts_lsb();
        return 32'sd1;
    endfunction

    function automatic int ent_data_lsb(input int tsw);
        return tsw + 32'sd1;
    endfunction

    function automatic int ent_width(input int dw, input int tsw);
        return dw + tsw + 32'sd1;
    endfunction

endpackage

// File: rtl/dvl_cap_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dvl_cap_fifo
    import dvl_cap_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 32'sd1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign level     = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = pop & ~empty & ~clr;
    assign w_do_push = push & (~full | w_do_pop) & ~clr;
    assign rdata     = empty ? {W{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the pointers qualify every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointer update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else if (clr) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/dvl_stream_capture.sv
// Passive valid/ready tap: timestamps every completed handshake into a FWFT FIFO
// and keeps overflow bookkeeping (saturating drop count, sticky flag, drop marker).
module dvl_stream_capture
    import dvl_cap_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   mon_vld,
    input  logic                   mon_rdy,
    input  logic [DW-1:0]          mon_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [DW-1:0]          out_data,
    output logic [TSW-1:0]         out_ts,
    output logic                   out_drop,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_CNT_W-1:0]  drop_cnt,
    output logic                   ovf
);

    localparam int EW       = ent_width(DW, TSW);
    localparam int DROP_LSB = ent_drop_lsb();
    localparam int TS_LSB   = ent_ts_lsb();
    localparam int DATA_LSB = ent_data_lsb(TSW);

    logic [TSW-1:0]        r_ts;
    logic                  r_pending_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  r_ovf;

    logic          w_cap;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;

    // clr gates capture, so a beat in the flush cycle is neither stored nor dropped.
    assign w_cap  = en & mon_vld & mon_rdy & ~clr;
    assign w_pop  = ~w_empty & out_rdy;
    assign w_push = w_cap & (~w_full | w_pop);
    assign w_drop = w_cap & w_full & ~w_pop;

    // Pack the stored entry from the tapped data, current timestamp and drop marker.
    always_comb begin
        w_wdata                       = {EW{1'b0}};
        w_wdata[DATA_LSB +: DW]       = mon_data;
        w_wdata[TS_LSB +: TSW]        = r_ts;
        w_wdata[DROP_LSB]             = r_pending_drop;
    end

    dvl_cap_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .push   (w_push),
        .pop    (w_pop),
        .wdata  (w_wdata),
        .rdata  (w_rdata),
        .full   (w_full),
        .empty  (w_empty),
        .level  (level)
    );

    assign out_vld  = ~w_empty;
    assign out_data = w_rdata[DATA_LSB +: DW];
    assign out_ts   = w_rdata[TS_LSB +: TSW];
    assign out_drop = w_rdata[DROP_LSB];
    assign drop_cnt = r_drop_cnt;
    assign ovf      = r_ovf;

    // Free-running timestamp, wrapping naturally at 2^TSW.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ts <= {TSW{1'b0}};
        end else if (clr) begin
            r_ts <= {TSW{1'b0}};
        end else begin
            r_ts <= r_ts + {{(TSW-1){1'b0}}, 1'b1};
        end
    end

    // Drop bookkeeping; the marker survives until the next successful write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt     <= {DROP_CNT_W{1'b0}};
            r_ovf          <= 1'b0;
            r_pending_drop <= 1'b0;
        end else if (clr) begin
            r_drop_cnt     <= {DROP_CNT_W{1'b0}};
            r_ovf          <= 1'b0;
            r_pending_drop <= 1'b0;
        end else if (w_drop) begin
            r_drop_cnt     <= (r_drop_cnt == DROP_CNT_MAX) ? r_drop_cnt
                                                           : r_drop_cnt + 16'd1;
            r_ovf          <= 1'b1;
            r_pending_drop <= 1'b1;
        end else if (w_push) begin
            r_pending_drop <= 1'b0;
        end else begin
            r_pending_drop <= r_pending_drop;
        end
    end

endmodule

// File: tb/tb_dvl_stream_capture.sv
// Self-checking bench: randomized stimulus compared against a queue-based model.
module tb_dvl_stream_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int TSW   = 32;

    logic          clk;
    logic          resetn;
    logic          en;
    logic          clr;
    logic          mon_vld;
    logic          mon_rdy;
    logic [31:0]   mon_data;
    logic          out_vld;
    logic          out_rdy;
    logic [31:0]   out_data;
    logic [31:0]   out_ts;
    logic          out_drop;
    logic [4:0]    level;
    logic [15:0]   drop_cnt;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    dvl_stream_capture #(.DW(DW), .DEPTH(DEPTH), .TSW(TSW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .clr      (clr),
        .mon_vld  (mon_vld),
        .mon_rdy  (mon_rdy),
        .mon_data (mon_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ts   (out_ts),
        .out_drop (out_drop),
        .level    (level),
        .drop_cnt (drop_cnt),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of entries plus scalar bookkeeping.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] ts;
        logic        drop;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_ts   = 32'd0;
    logic [15:0] m_cnt  = 16'd0;
    logic        m_ovf  = 1'b0;
    logic        m_pend = 1'b0;

    wire [87:0] dut_vec = {out_vld, out_data, out_ts, out_drop, level, drop_cnt, ovf};

    function automatic void model_clear();
        mq.delete();
        m_ts   = 32'd0;
        m_cnt  = 16'd0;
        m_ovf  = 1'b0;
        m_pend = 1'b0;
    endfunction

    function automatic void model_step();
        ent_t e;
        if (!resetn || clr) begin
            model_clear();
        end else begin
            if (out_rdy && mq.size() > 0) void'(mq.pop_front());
            if (en && mon_vld && mon_rdy) begin
                if (mq.size() < DEPTH) begin
                    e.data = mon_data;
                    e.ts   = m_ts;
                    e.drop = m_pend;
                    mq.push_back(e);
                    m_pend = 1'b0;
                end else begin
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    m_ovf  = 1'b1;
                    m_pend = 1'b1;
                end
            end
            m_ts = m_ts + 32'd1;
        end
    endfunction

    function automatic logic [87:0] model_vec();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        return {(mq.size() != 0), h.data, h.ts, h.drop, 5'(mq.size()), m_cnt, m_ovf};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; clr = 1'b0; mon_vld = 1'b0; mon_rdy = 1'b0; out_rdy = 1'b0;
        mon_data = $urandom;
    endtask

    task automatic flush();
        idle_inputs();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) cycle();
        checks++;
        if (dut_vec !== 88'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, 88'd0);
        end
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3;
        idle_inputs();
        repeat (5) cycle();
        mon_vld = 1'b1; mon_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mon_data = exp_d[i];
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL b2b_capture i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        mon_vld = 1'b0;
        checks++;
        if (level !== 5'd3) begin
            failures++;
            $display("FAIL b2b_level got=%0d exp=3", level);
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_vld, out_data, out_ts, out_drop} !== {1'b1, exp_d[i], 32'd5 + 32'(i), 1'b0}) begin
                failures++;
                $display("FAIL b2b_head i=%0d got=%h/%0d/%b exp=%h/%0d/0",
                         i, out_data, out_ts, out_drop, exp_d[i], 5 + i);
            end
            cycle();
        end
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty got=%b exp=0", out_vld);
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] x_data;
        flush();
        mon_vld = 1'b1; mon_rdy = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            mon_data = $urandom;
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL ovf_fill i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++;
        if ({drop_cnt, ovf, level} !== {16'd2, 1'b1, 5'd16}) begin
            failures++;
            $display("FAIL ovf_counts got cnt=%0d ovf=%b lvl=%0d exp cnt=2 ovf=1 lvl=16",
                     drop_cnt, ovf, level);
        end
        mon_vld = 1'b0; out_rdy = 1'b1;
        cycle();
        out_rdy = 1'b0; mon_vld = 1'b1; mon_data = 32'hBB;
        cycle();
        out_rdy = 1'b1; x_data = $urandom; mon_data = x_data;
        cycle();
        mon_vld = 1'b0;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            cycle();
        end
        checks++;
        if ({out_data, out_drop} !== {32'hBB, 1'b1}) begin
            failures++;
            $display("FAIL ovf_marked got=%h/%b exp=bb/1", out_data, out_drop);
        end
        cycle();
        checks++;
        if ({out_vld, out_data, out_drop} !== {1'b1, x_data, 1'b0}) begin
            failures++;
            $display("FAIL ovf_after got=%b/%h/%b exp=1/%h/0", out_vld, out_data, out_drop, x_data);
        end
        cycle();
        out_rdy = 1'b0;
    endtask

    task automatic test_full_cap_pop();
        logic [31:0] n_data;
        flush();
        mon_vld = 1'b1; mon_rdy = 1'b1;
        repeat (DEPTH) begin
            mon_data = $urandom;
            cycle();
        end
        n_data = $urandom; mon_data = n_data; out_rdy = 1'b1;
        cycle();
        mon_vld = 1'b0;
        checks++;
        if ({level, drop_cnt, ovf} !== {5'd16, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL fullpop_level got lvl=%0d cnt=%0d ovf=%b exp lvl=16 cnt=0 ovf=0",
                     level, drop_cnt, ovf);
        end
        repeat (DEPTH - 1) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL fullpop_drain got=%h exp=%h", dut_vec, model_vec());
            end
            cycle();
        end
        checks++;
        if ({out_vld, out_data, level} !== {1'b1, n_data, 5'd1}) begin
            failures++;
            $display("FAIL fullpop_tail got=%b/%h/%0d exp=1/%h/1", out_vld, out_data, level, n_data);
        end
        cycle();
        out_rdy = 1'b0;
    endtask

    task automatic test_no_capture();
        flush();
        mon_vld = 1'b1; mon_rdy = 1'b0;
        repeat (10) cycle();
        en = 1'b0; mon_rdy = 1'b1;
        repeat (5) cycle();
        checks++;
        if ({out_vld, level} !== {1'b0, 5'd0} || dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL no_capture got vld=%b lvl=%0d exp vld=0 lvl=0", out_vld, level);
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        flush();
        mon_vld = 1'b1; mon_rdy = 1'b1;
        repeat (DEPTH) cycle();
        repeat (65534) cycle();
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_pre got=%h exp=fffe", drop_cnt);
        end
        cycle();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hit got=%h exp=ffff", drop_cnt);
        end
        repeat (70000 - 65535) cycle();
        checks++;
        if (dut_vec !== model_vec() || drop_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=%h", dut_vec, model_vec());
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checks++;
        if ({out_vld, level, drop_cnt, ovf} !== {1'b0, 5'd0, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL clr_state got vld=%b lvl=%0d cnt=%0d ovf=%b exp all 0",
                     out_vld, level, drop_cnt, ovf);
        end
        mon_data = 32'h5A5A;
        cycle();
        mon_vld = 1'b0;
        checks++;
        if ({out_vld, out_data, out_ts, level} !== {1'b1, 32'h5A5A, 32'd0, 5'd1}) begin
            failures++;
            $display("FAIL clr_ts got=%b/%h/%0d/%0d exp=1/5a5a/0/1", out_vld, out_data, out_ts, level);
        end
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 99) == 0);
            mon_vld  = $urandom_range(0, 1) == 1;
            mon_rdy  = ($urandom_range(0, 3) != 0);
            out_rdy  = ($urandom_range(0, 2) == 0);
            mon_data = $urandom;
            cycle();
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random i=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        flush();
        mon_vld = 1'b1; mon_rdy = 1'b1;
        repeat (5) cycle();
        checks++;
        if (level !== 5'd5) begin
            failures++;
            $display("FAIL areset_pre got=%0d exp=5", level);
        end
        #3;
        resetn = 1'b0;
        model_clear();
        #1;
        checks++;
        if (dut_vec !== 88'd0) begin
            failures++;
            $display("FAIL areset_now got=%h exp=0", dut_vec);
        end
        cycle();
        cycle();
        resetn = 1'b1;
        mon_data = 32'hC0DE;
        cycle();
        mon_vld = 1'b0;
        checks++;
        if ({out_vld, out_data, out_ts, level} !== {1'b1, 32'hC0DE, 32'd0, 5'd1}) begin
            failures++;
            $display("FAIL areset_first got=%b/%h/%0d/%0d exp=1/c0de/0/1", out_vld, out_data, out_ts, level);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_full_cap_pop();
        test_no_capture();
        test_random();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvl_stream_capture.md
Name: dvl_stream_capture

Overview:
- Synthesizable capture stage directly upstream of the monitor component.
- Passively taps a valid/ready stream at the DUT boundary and timestamps every completed handshake. It buffers the beats in a FIFO and presents them on a pop interface that the monitor drains at its own pace.
- Counts overflow drops and flags the first entry stored after any drop, so the monitor and scoreboard can tell when data was lost.

Parameters:
- DW, 32: width of captured stream data.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- TSW, 32: timestamp width; the timestamp counter wraps modulo 2^TSW.

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
- en  in  1  capture enable; when low, handshakes are ignored and not counted.
- clr  in  1  synchronous flush of FIFO, counters and flags.
- mon_vld  in  1  tapped stream valid.
- mon_rdy  in  1  tapped stream ready.
- mon_data  in  DW  tapped stream data.
- out_vld  out  1  FIFO not empty.
- out_rdy  in  1  consumer pop request.
- out_data  out  DW  head entry data.
- out_ts  out  TSW  head entry timestamp.
- out_drop  out  1  one or more beats were dropped immediately before this entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  dropped-beat count, saturating.
- ovf  out  1  sticky: at least one drop since reset or clr.

Behaviour:
- Reset (resetn low, async) and clr (sync): all of the following return to zero:
  - timestamp counter, read/write pointers, level, drop_cnt, ovf, pending_drop
  - out_vld=0; out_data, out_ts and out_drop drive 0 while empty
- Timestamp: ts increments by 1 every cycle and wraps from 2^TSW-1 to 0.
- Capture event: cap = en & mon_vld & mon_rdy & ~clr. clr has priority; a capture in the clr cycle is discarded and not counted as a drop.
- Pop event: pop = out_vld & out_rdy. Popping while empty has no effect.
- Stored entry = {mon_data, ts value in the capture cycle, pending_drop}.
- Latency: a beat captured in cycle N appears at the head (out_vld=1) in cycle N+1 when the FIFO was empty. The interface is first-word fall-through.
- Head outputs are stable while out_vld=1 and out_rdy=0.
- Push/pop rules:
  - cap & ~full: write the entry, then clear pending_drop.
  - cap & full & pop (same cycle): the push is accepted and level is unchanged. Full is evaluated after the pop, so no drop occurs.
  - cap & full & ~pop: the beat is dropped. drop_cnt increments, saturating at 0xFFFF. ovf<=1. pending_drop<=1.
  - cap & pop, not full: level is unchanged; both pointers advance.
- Simultaneous drop and clr cannot occur (clr gates cap).
- pending_drop stays set across cycles until the next successful write. That entry carries out_drop=1; later entries carry 0 unless further drops happen.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits. full = MSBs differ and the rest are equal; empty = pointers equal. level = wr_ptr - rd_ptr.
- en low: the FIFO still drains via pop; ts keeps running.
- resetn asserted mid-burst: contents are lost. On release, ts restarts at 0 and the first capture carries ts=0 or later.

Decomposition:
- Package dvl_cap_pkg holds:
  - constants DROP_CNT_W=16, DROP_CNT_MAX=16'hFFFF
  - a function computing the pointer width from DEPTH
  - parameterized entry layout offsets (data, ts, drop bit)
- Sub-module dvl_cap_fifo: generic FWFT synchronous FIFO.
  - Ports: clk, resetn, clr, push, pop, wdata, rdata, full, empty, level.
  - The top contains only the ts counter, capture/drop logic and drop bookkeeping.

Test Plan:
- Reset then 3 back-to-back handshakes (data 0xA1, 0xA2, 0xA3 at ts 5, 6, 7) with out_rdy=0 → level=3. Then assert out_rdy → pops 0xA1/5, 0xA2/6, 0xA3/7, all with out_drop=0, then out_vld=0.
- Fill 16 entries with out_rdy=0, then 2 more handshakes → drop_cnt=2, ovf=1, level=16. Pop one, capture 0xBB → 0xBB stored with out_drop=1; the next capture has out_drop=0.
- FIFO full, cap and pop in the same cycle → level stays 16, drop_cnt=0, the new entry is present at the tail.
- mon_vld=1, mon_rdy=0 for 10 cycles, or en=0 with a handshake → no entries stored, level=0.
- Force 70000 drops → drop_cnt saturates at 0xFFFF. Pulse clr while cap is active → level=0, drop_cnt=0, ovf=0, ts=0 next cycle, no entry stored.
- Assert resetn low asynchronously mid-capture with level=5 → all outputs zero immediately. After release, the first capture carries ts from a restarted counter.
